// File: rtl/mod_down_counter.sv
// Modulo-N down counter / countdown timer.
// IDLE/RUN/PAUSED control with auto-reload or one-shot expiry.
module mod_down_counter #(
  parameter int WIDTH       = 2,
  parameter int MODULUS     = 4,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             wrap,
  output logic             done
);

  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
    $error("MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             running_q, running_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    if (start) begin
      state_d = RUN;
      count_d = TOP;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end else if (AUTO_RELOAD) begin
            count_d = TOP;
            wrap_d  = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        PAUSED: begin
          // resume costs one edge with no decrement
          if (!pause) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign wrap    = wrap_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mod_down_counter.sv
// Bench for mod_down_counter: three configurations driven in lockstep
// and compared against a behavioural timer model every cycle.
module tb_mod_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] cnt [3];
  logic       run [3];
  logic       wr  [3];
  logic       dn  [3];

  int errors = 0;
  int checks = 0;

  // 0: defaults, 1: one-shot, 2: modulus 3
  int mod_v [3] = '{4, 4, 3};
  bit ar_v  [3] = '{1'b1, 1'b0, 1'b1};

  // model: phase 0 idle, 1 counting, 2 held
  int m_phase [3];
  int m_cnt   [3];
  int m_wrap  [3];
  int m_done  [3];

  always #5 clk = ~clk;

  mod_down_counter u_def (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .count(cnt[0]), .running(run[0]), .wrap(wr[0]), .done(dn[0])
  );

  mod_down_counter #(.AUTO_RELOAD(1'b0)) u_one (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .count(cnt[1]), .running(run[1]), .wrap(wr[1]), .done(dn[1])
  );

  mod_down_counter #(.MODULUS(3)) u_m3 (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .count(cnt[2]), .running(run[2]), .wrap(wr[2]), .done(dn[2])
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_phase[i] = 0;
      m_cnt[i]   = 0;
      m_wrap[i]  = 0;
      m_done[i]  = 0;
    end
  endtask

  task automatic model_edge(input bit s, input bit p);
    for (int i = 0; i < 3; i++) begin
      m_wrap[i] = 0;
      m_done[i] = 0;
      if (s) begin
        m_phase[i] = 1;
        m_cnt[i]   = mod_v[i] - 1;
      end else if (m_phase[i] == 1) begin
        if (p) m_phase[i] = 2;
        else if (m_cnt[i] > 0) m_cnt[i]--;
        else if (ar_v[i]) begin
          m_cnt[i]  = mod_v[i] - 1;
          m_wrap[i] = 1;
        end else begin
          m_phase[i] = 0;
          m_done[i]  = 1;
        end
      end else if (m_phase[i] == 2) begin
        if (!p) m_phase[i] = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("count%0d", i), int'(cnt[i]), m_cnt[i]);
      check($sformatf("running%0d", i), int'(run[i]),
            int'(m_phase[i] == 1));
      check($sformatf("wrap%0d", i), int'(wr[i]), m_wrap[i]);
      check($sformatf("done%0d", i), int'(dn[i]), m_done[i]);
    end
  endtask

  task automatic step(input bit s, input bit p);
    start = s;
    pause = p;
    @(posedge clk);
    model_edge(s, p);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // free run: wrap / expiry / modulus-3 sequences
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // hold at 2 for three cycles, then resume
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);

    // restart while running at 1, then while paused
    step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // asynchronous reset mid-count
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    async_reset();
    repeat (3) step(1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      if (n == 200) async_reset();
      step(($urandom % 16) == 0, ($urandom % 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
